// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
//   Shared types and constants for the direct-mapped instruction cache.
//   A line is 16 bytes (four 32-bit words, little-endian: word k sits at
//   bits [32k+31:32k]). The refill controller has two states: IDLE and REFILL.
// -----------------------------------------------------------------------------
package icache_pkg;

  localparam int LINE_BYTES     = 16;
  localparam int OFFSET_BITS    = 4;
  localparam int WORDS_PER_LINE = 4;

  typedef logic [8*LINE_BYTES-1:0] line_t;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } icache_state_t;

endpackage : icache_pkg

// File: rtl/icache_store.sv
// -----------------------------------------------------------------------------
// icache_store
//   Valid / tag / data arrays of the direct-mapped instruction cache.
//
//   Ports
//     clk         sole clock, rising edge
//     rst         synchronous active-high reset (clears valid bits only)
//     clear_i     synchronous clear of all valid bits (flush)
//     rd_index_i  asynchronous read index
//     rd_valid_o  valid bit of the indexed set
//     rd_tag_o    stored tag of the indexed set
//     rd_line_o   stored line of the indexed set
//     wr_en_i     write the line/tag at wr_index_i and mark it valid
//     wr_index_i  write index
//     wr_tag_i    tag to store
//     wr_line_i   line data to store
// -----------------------------------------------------------------------------
module icache_store
  import icache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int INDEX_BITS = $clog2(SETS),
  parameter int TAG_BITS   = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic [INDEX_BITS-1:0]   rd_index_i,
  output logic                    rd_valid_o,
  output logic [TAG_BITS-1:0]     rd_tag_o,
  output logic [8*LINE_BYTES-1:0] rd_line_o,
  input  logic                    wr_en_i,
  input  logic [INDEX_BITS-1:0]   wr_index_i,
  input  logic [TAG_BITS-1:0]     wr_tag_i,
  input  logic [8*LINE_BYTES-1:0] wr_line_i
);

  logic [SETS-1:0]     valid_q;
  logic [TAG_BITS-1:0] tag_q  [SETS];
  line_t               data_q [SETS];

  // Clear has priority over a same-cycle write: a flush never leaves a
  // freshly written line valid.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst || clear_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  // NOTE: tag and data storage carry no reset; the valid bits alone decide
  // whether their contents mean anything, and leaving them unreset lets the
  // arrays map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_line_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_line_o  = data_q[rd_index_i];

endmodule : icache_store

// File: rtl/icache_direct.sv
// -----------------------------------------------------------------------------
// icache_direct
//   Direct-mapped instruction cache between the fetch PC and a line-wide ROM.
//   Hits return the word in the same cycle; a miss stalls fetch for
//   REFILL_LATENCY+1 cycles while the line is refilled, then the held PC hits.
//
//   Ports
//     clk          sole clock, rising edge
//     rst          synchronous active-high reset
//     req          fetch request valid
//     pc           fetch byte address (bits [1:0] ignored)
//     flush        invalidate all lines; aborts a refill in progress
//     instr        instruction word for pc (0 when not a hit)
//     instr_valid  instr is valid (hit)
//     stall        fetch must hold pc
//     mem_rd       refill in progress
//     mem_addr     line address being refilled (0 when idle)
//     mem_line     line data from the ROM for mem_addr
//     miss_count   number of refills started, wraps at 2^32
// -----------------------------------------------------------------------------
module icache_direct
  import icache_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int SETS           = 64,
  parameter int REFILL_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  logic                     flush,
  output logic [31:0]              instr,
  output logic                     instr_valid,
  output logic                     stall,
  output logic                     mem_rd,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [8*LINE_BYTES-1:0]  mem_line,
  output logic [31:0]              miss_count
);

  localparam int INDEX_BITS = $clog2(SETS);
  localparam int TAG_BITS   = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int LINE_BITS  = ADDRESS_WIDTH - OFFSET_BITS;
  localparam int CNT_W      = (REFILL_LATENCY > 1) ? $clog2(REFILL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFILL_LATENCY - 1);

  icache_state_t        state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [LINE_BITS-1:0] miss_line_q;   // miss address without the zero offset
  logic [31:0]          miss_count_q;
  logic                 mem_rd_q;

  logic [TAG_BITS-1:0]   pc_tag;
  logic [INDEX_BITS-1:0] pc_index;
  logic [1:0]            word_sel;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  line_t                 rd_line;
  logic                  hit;
  logic                  miss_start;
  logic                  refill_done;
  logic                  wr_en;
  logic                  unused_pc_bits;

  assign pc_tag         = pc[ADDRESS_WIDTH-1 -: TAG_BITS];
  assign pc_index       = pc[OFFSET_BITS +: INDEX_BITS];
  assign word_sel       = pc[3:2];
  assign unused_pc_bits = ^pc[1:0];

  icache_store #(
    .SETS       (SETS),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (flush),
    .rd_index_i (pc_index),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .wr_en_i    (wr_en),
    .wr_index_i (miss_line_q[INDEX_BITS-1:0]),
    .wr_tag_i   (miss_line_q[INDEX_BITS +: TAG_BITS]),
    .wr_line_i  (mem_line)
  );

  // Lookups only count while idle, so a refill's own target never hits
  // against the line being written.
  assign hit         = req && rd_valid && (rd_tag == pc_tag) && (state_q == IDLE);
  assign instr_valid = hit;
  assign instr       = hit ? rd_line[{word_sel, 5'b0} +: 32] : 32'h0;
  assign stall       = ((state_q == IDLE) && req && !hit) || (state_q == REFILL);

  // A flush in the same cycle as a miss wins: nothing is fetched or counted.
  assign miss_start  = (state_q == IDLE) && req && !hit && !flush;
  assign refill_done = (state_q == REFILL) && (cnt_q == CNT_LAST);
  assign wr_en       = refill_done && !flush;

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_rd_q ? {miss_line_q, {OFFSET_BITS{1'b0}}} : '0;
  assign miss_count  = miss_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      miss_line_q  <= '0;
      miss_count_q <= '0;
      mem_rd_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_start) begin
            miss_line_q  <= pc[ADDRESS_WIDTH-1:OFFSET_BITS];
            cnt_q        <= '0;
            miss_count_q <= miss_count_q + 32'd1;
            mem_rd_q     <= 1'b1;
            state_q      <= REFILL;
          end
        end
        REFILL: begin
          // The ROM line is captured by the store on the last counted cycle;
          // a flush abandons the refill without writing it.
          if (flush || refill_done) begin
            cnt_q    <= '0;
            mem_rd_q <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          mem_rd_q <= 1'b0;
        end
      endcase
    end
  end

endmodule : icache_direct
